fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Write-side port of the 640x480 framebuffer; the VGA display controller is the read side.
- Accepts (x, y, rgb) pixels from the drawing logic over a valid/ready handshake, clips them and converts coordinates to a linear framebuffer address.
- Issues registered write strobes to the framebuffer RAM.
- Contains a clear-screen engine that fills the whole frame with one colour.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDR_W, 19, framebuffer address width; H_RES*V_RES must fit in 2^ADDR_W

Ports:
- clk_50  input  1  system clock, 50 MHz
- rst  input  1  synchronous active-high reset
- pix_valid  input  1  pixel request valid
- pix_ready  output  1  pixel request accepted when pix_valid && pix_ready
- pix_x  input  10  column
- pix_y  input  9  row
- pix_rgb  input  24  {r[7:0], g[7:0], b[7:0]}
- clear_req  input  1  one-cycle pulse; starts a frame clear
- clear_color  input  24  fill colour, sampled with clear_req
- clear_busy  output  1  high while the clear engine is active
- clear_done  output  1  one-cycle pulse after the last clear write completes
- pix_clipped  output  1  one-cycle pulse when an accepted pixel is out of range
- fb_we  output  1  framebuffer write strobe
- fb_addr  output  ADDR_W  write address
- fb_wdata  output  24  write data
- fb_stall  input  1  RAM back-pressure; a write completes on a cycle with fb_we && !fb_stall

Behaviour:
- Reset: all outputs 0 except pix_ready; state IDLE; clear counter 0. pix_ready returns 1 in the first cycle after reset deasserts.
- Output register (fb_we/fb_addr/fb_wdata) is a single slot. It is free when !fb_we || !fb_stall. While fb_stall is high, fb_we, fb_addr and fb_wdata hold stable.
- pix_ready = (state==IDLE) && !clear_req && slot free. Combinational, with no dependence on pix_valid.
- Pixel path:
  - On accept, fb_addr = pix_y*H_RES + pix_x, computed at ADDR_W width. With H_RES=640 this is (y<<9)+(y<<7)+x, with no multiplier.
  - fb_we rises the cycle after accept (latency 1), and fb_wdata = pix_rgb.
  - Back-to-back accepts give one write per cycle.
- Clipping: if pix_x >= H_RES or pix_y >= V_RES, the pixel is still accepted, no write is issued, and pix_clipped pulses the next cycle.
- FSM:
  - IDLE -> CLEAR on clear_req. clear_color is latched, the counter is set to 0, and clear_busy rises the next cycle.
  - clear_req has priority over a simultaneous pix_valid; that pixel is not accepted.
  - CLEAR: each cycle the slot is free, issue a write with addr = counter and data = latched colour, then increment the counter. A pixel write still stalled in the slot drains first.
  - When the write of address H_RES*V_RES-1 completes, go to DONE.
  - DONE: clear_done = 1 for one cycle, clear_busy = 0, then IDLE.
  - clear_req while in CLEAR or DONE is ignored.
- rst mid-clear: clear abandoned, fb_we = 0 on the next edge, no clear_done.
- Counter is ADDR_W wide and never wraps: its terminal value is H_RES*V_RES-1.

Optional Feature:
- Macro: FB_WRITER_CLIP_CNT_EN.
- When defined: adds output clip_count[15:0], which increments on every pix_clipped, saturates at 16'hFFFF and is cleared by rst or by the clear_req that starts a clear.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fb_pkg holds:
  - FB_H_RES = 640, FB_V_RES = 480, FB_ADDR_W = 19
  - FB_PIXELS = FB_H_RES*FB_V_RES
  - The state encoding: IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2
  - The 24-bit rgb word layout
- One sub-module: fb_xy_to_addr. It is a combinational shift-add address generator with a clip flag, reusable by later read-side blocks.

Test Plan:
- Reset: hold rst 3 cycles -> fb_we = 0, clear_busy = 0, clear_done = 0; pix_ready = 1 one cycle after release.
- Single pixel: x = 5, y = 2, rgb = 24'h112233, stall = 0 -> next cycle fb_we = 1, fb_addr = 1285, fb_wdata = 24'h112233, for exactly one cycle.
- Clip: x = 640, y = 0 -> accepted, no fb_we, pix_clipped pulses once. Then x = 639, y = 479 -> fb_addr = 307199.
- Stall: two back-to-back pixels with fb_stall high for 4 cycles after the first write appears -> first write held stable 4 cycles, pix_ready = 0 meanwhile, second write follows with no loss or duplication.
- Clear, with H_RES = 8, V_RES = 4, colour 24'hFF0000:
  - Expect 32 writes, addresses 0..31 in order.
  - clear_done pulses once after address 31 completes.
  - A random fb_stall variant must also give exactly 32 completed writes.
- Simultaneous clear_req and pix_valid in IDLE -> pixel not accepted, clear runs. After rst asserted mid-clear at address 10 -> no further writes and no clear_done.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, writer FSM encoding and the 24-bit pixel layout.
package fb_pkg;
  localparam int FB_H_RES  = 640;
  localparam int FB_V_RES  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = FB_H_RES * FB_V_RES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } fb_rgb_t;
endpackage

// File: rtl/fb_xy_to_addr.sv
// Combinational (x, y) -> linear framebuffer address with an out-of-frame clip flag.
module fb_xy_to_addr
  import fb_pkg::*;
#(
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              clip
);
  logic [ADDR_W-1:0] xw;
  logic [ADDR_W-1:0] yw;

  assign xw = ADDR_W'(x);
  assign yw = ADDR_W'(y);

  // 640 = 512 + 128, so the standard line length needs only two shifts and an add.
  generate
    if (H_RES == 640) begin : g_640
      assign addr = (yw << 9) + (yw << 7) + xw;
    end else begin : g_generic
      assign addr = yw * ADDR_W'(H_RES) + xw;
    end
  endgenerate

  assign clip = (32'(x) >= H_RES) || (32'(y) >= V_RES);
endmodule

// File: rtl/fb_pixel_writer.sv
// Write-side framebuffer port: clipped pixel writes plus a whole-frame clear engine.
// Optional saturating clip counter output enabled by `define FB_WRITER_CLIP_CNT_EN.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [8:0]        pix_y,
  input  logic [23:0]       pix_rgb,
  input  logic              clear_req,
  input  logic [23:0]       clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              pix_clipped,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_wdata,
  input  logic              fb_stall
`ifdef FB_WRITER_CLIP_CNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  fb_state_t         state;
  fb_state_t         state_nxt;
  logic              slot_free;
  logic              accept;
  logic              clear_start;
  logic              clear_issue;
  logic              last_issued;
  logic              last_done;
  logic [ADDR_W-1:0] clear_cnt;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_clip;
  fb_rgb_t           fill_rgb;

  fb_xy_to_addr #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_xy_to_addr (
    .x    (pix_x),
    .y    (pix_y),
    .addr (pix_addr),
    .clip (pix_clip)
  );

  assign slot_free = !fb_we || !fb_stall;
  assign accept    = pix_valid && pix_ready;
  // Only the final clear write can be in the slot once last_issued is set.
  assign last_done = last_issued && fb_we && !fb_stall;

  always_ff @(posedge clk_50) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (last_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready   = (state == IDLE) && !clear_req && slot_free && !rst;
    clear_start = (state == IDLE) && clear_req && !rst;
    clear_issue = (state == CLEAR) && slot_free && !last_issued;
    clear_busy  = (state == CLEAR);
    clear_done  = (state == DONE);
  end

  // Clear address counter holds at the terminal address rather than wrapping.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      clear_cnt   <= '0;
      last_issued <= 1'b0;
    end else if (clear_start) begin
      clear_cnt   <= '0;
      last_issued <= 1'b0;
    end else if (clear_issue) begin
      if (clear_cnt == LAST_ADDR) last_issued <= 1'b1;
      else                        clear_cnt   <= clear_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (clear_start) fill_rgb <= clear_color;
  end

  // Output slot: loads only when free, otherwise holds stable under fb_stall.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else if (slot_free) begin
      if (clear_issue) begin
        fb_we    <= 1'b1;
        fb_addr  <= clear_cnt;
        fb_wdata <= fill_rgb;
      end else if (accept && !pix_clip) begin
        fb_we    <= 1'b1;
        fb_addr  <= pix_addr;
        fb_wdata <= pix_rgb;
      end else begin
        fb_we    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) pix_clipped <= 1'b0;
    else     pix_clipped <= accept && pix_clip;
  end

`ifdef FB_WRITER_CLIP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_50) begin
    if (rst || clear_start) clip_count <= '0;
    else if (pix_clipped)   clip_count <= sat_inc16(clip_count);
  end
`endif
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: full-size instance for pixel paths, 8x4 instance for clears.
module tb_fb_pixel_writer;
  typedef logic [42:0] wr_t;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  int          checks = 0;
  int          passes = 0;
  wr_t         exp_q[$];
  wr_t         exp_q_s[$];

  logic        pix_valid, pix_ready, clear_req, clear_busy, clear_done, pix_clipped, fb_we, fb_stall;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb, clear_color, fb_wdata;
  logic [18:0] fb_addr;

  logic        pix_valid_s, pix_ready_s, clear_req_s, clear_busy_s, clear_done_s, pix_clipped_s, fb_we_s, fb_stall_s;
  logic [9:0]  pix_x_s;
  logic [8:0]  pix_y_s;
  logic [23:0] pix_rgb_s, clear_color_s, fb_wdata_s;
  logic [18:0] fb_addr_s;
`ifdef FB_WRITER_CLIP_CNT_EN
  logic [15:0] clip_count, clip_count_s;
`endif

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk_50(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
    .pix_clipped(pix_clipped), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_stall(fb_stall)
`ifdef FB_WRITER_CLIP_CNT_EN
    , .clip_count(clip_count)
`endif
  );

  fb_pixel_writer #(.H_RES(8), .V_RES(4), .ADDR_W(19)) dut_s (
    .clk_50(clk), .rst(rst_s), .pix_valid(pix_valid_s), .pix_ready(pix_ready_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_rgb(pix_rgb_s), .clear_req(clear_req_s),
    .clear_color(clear_color_s), .clear_busy(clear_busy_s), .clear_done(clear_done_s),
    .pix_clipped(pix_clipped_s), .fb_we(fb_we_s), .fb_addr(fb_addr_s), .fb_wdata(fb_wdata_s),
    .fb_stall(fb_stall_s)
`ifdef FB_WRITER_CLIP_CNT_EN
    , .clip_count(clip_count_s)
`endif
  );

  // Scoreboards: every completed write pops and compares the oldest expected write.
  always @(negedge clk) begin
    if (fb_we === 1'b1 && fb_stall === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL main_write unexpected addr=%0d data=%h want=none", fb_addr, fb_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({fb_addr, fb_wdata} !== e)
          $display("FAIL main_write addr=%0d data=%h want addr=%0d data=%h", fb_addr, fb_wdata, e[42:24], e[23:0]);
        else passes++;
      end
    end
  end

  always @(negedge clk) begin
    if (fb_we_s === 1'b1 && fb_stall_s === 1'b0) begin
      checks++;
      if (exp_q_s.size() == 0) begin
        $display("FAIL small_write unexpected addr=%0d data=%h want=none", fb_addr_s, fb_wdata_s);
      end else begin
        wr_t e;
        e = exp_q_s.pop_front();
        if ({fb_addr_s, fb_wdata_s} !== e)
          $display("FAIL small_write addr=%0d data=%h want addr=%0d data=%h", fb_addr_s, fb_wdata_s, e[42:24], e[23:0]);
        else passes++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) $display("FAIL reset_fb_we got=%b want=0", fb_we); else passes++;
    checks++; if (clear_busy !== 1'b0) $display("FAIL reset_clear_busy got=%b want=0", clear_busy); else passes++;
    checks++; if (clear_done !== 1'b0) $display("FAIL reset_clear_done got=%b want=0", clear_done); else passes++;
    checks++; if (pix_clipped !== 1'b0) $display("FAIL reset_pix_clipped got=%b want=0", pix_clipped); else passes++;
    checks++; if (fb_we_s !== 1'b0 || pix_clipped_s !== 1'b0) $display("FAIL reset_small we=%b clipped=%b want=0", fb_we_s, pix_clipped_s); else passes++;
    @(posedge clk); #1;
    rst = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready got=%b want=1", pix_ready); else passes++;
    checks++; if (pix_ready_s !== 1'b1) $display("FAIL reset_pix_ready_s got=%b want=1", pix_ready_s); else passes++;
  endtask

  task automatic test_single_pixel();
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_x = 10'd5; pix_y = 9'd2; pix_rgb = 24'h112233;
    exp_q.push_back({19'd1285, 24'h112233});
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) $display("FAIL single_ready got=%b want=1", pix_ready); else passes++;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++; if (fb_we !== 1'b1) $display("FAIL single_we got=%b want=1", fb_we); else passes++;
    checks++; if (fb_addr !== 19'd1285) $display("FAIL single_addr got=%0d want=1285", fb_addr); else passes++;
    checks++; if (fb_wdata !== 24'h112233) $display("FAIL single_data got=%h want=112233", fb_wdata); else passes++;
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) $display("FAIL single_we_drop got=%b want=0", fb_we); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL single_pending got=%0d want=0", exp_q.size()); else passes++;
  endtask

  task automatic test_clip();
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_x = 10'd640; pix_y = 9'd0; pix_rgb = 24'h777777;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) $display("FAIL clip_ready got=%b want=1", pix_ready); else passes++;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++; if (pix_clipped !== 1'b1) $display("FAIL clip_pulse got=%b want=1", pix_clipped); else passes++;
    checks++; if (fb_we !== 1'b0) $display("FAIL clip_no_write got=%b want=0", fb_we); else passes++;
    @(negedge clk);
    checks++; if (pix_clipped !== 1'b0) $display("FAIL clip_pulse_end got=%b want=0", pix_clipped); else passes++;
`ifdef FB_WRITER_CLIP_CNT_EN
    checks++; if (clip_count !== 16'd1) $display("FAIL clip_count got=%0d want=1", clip_count); else passes++;
`endif
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_x = 10'd639; pix_y = 9'd479; pix_rgb = 24'hABCDEF;
    exp_q.push_back({19'd307199, 24'hABCDEF});
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++; if (fb_we !== 1'b1 || fb_addr !== 19'd307199) $display("FAIL corner_addr we=%b addr=%0d want we=1 addr=307199", fb_we, fb_addr); else passes++;
    checks++; if (pix_clipped !== 1'b0) $display("FAIL corner_not_clipped got=%b want=0", pix_clipped); else passes++;
    @(negedge clk);
    checks++; if (exp_q.size() != 0) $display("FAIL clip_pending got=%0d want=0", exp_q.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_x = 10'd1; pix_y = 9'd1; pix_rgb = 24'hA0A0A0;
    exp_q.push_back({19'd641, 24'hA0A0A0});
    @(posedge clk); #1;
    pix_x = 10'd2; pix_y = 9'd3; pix_rgb = 24'hB1B1B1; fb_stall = 1'b1;
    exp_q.push_back({19'd1922, 24'hB1B1B1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== 19'd641 || fb_wdata !== 24'hA0A0A0)
        $display("FAIL stall_hold%0d we=%b addr=%0d data=%h want we=1 addr=641 data=a0a0a0", i, fb_we, fb_addr, fb_wdata);
      else passes++;
      checks++; if (pix_ready !== 1'b0) $display("FAIL stall_ready%0d got=%b want=0", i, pix_ready); else passes++;
      @(posedge clk); #1;
    end
    fb_stall = 1'b0;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) $display("FAIL stall_release_ready got=%b want=1", pix_ready); else passes++;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++; if (fb_we !== 1'b1 || fb_addr !== 19'd1922) $display("FAIL stall_second we=%b addr=%0d want we=1 addr=1922", fb_we, fb_addr); else passes++;
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) $display("FAIL stall_dup got=%b want=0", fb_we); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL stall_pending got=%0d want=0", exp_q.size()); else passes++;
  endtask

  task automatic test_clear(input bit rand_stall, input logic [23:0] col);
    int done_cnt = 0;
    int extra = 0;
    int cyc = 0;
    @(posedge clk); #1;
    clear_req_s = 1'b1; clear_color_s = col;
    for (int i = 0; i < 32; i++) exp_q_s.push_back({19'(i), col});
    @(negedge clk);
    checks++; if (pix_ready_s !== 1'b0) $display("FAIL clear_req_ready got=%b want=0", pix_ready_s); else passes++;
    @(posedge clk); #1;
    clear_req_s = 1'b0; clear_color_s = 24'h000000;
    @(negedge clk);
    checks++; if (clear_busy_s !== 1'b1) $display("FAIL clear_busy got=%b want=1", clear_busy_s); else passes++;
    while (done_cnt == 0 && cyc < 400) begin
      @(posedge clk); #1;
      fb_stall_s = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (clear_done_s === 1'b1) begin
        done_cnt++;
        checks++; if (exp_q_s.size() != 0) $display("FAIL clear_done_early pending=%0d want=0", exp_q_s.size()); else passes++;
        checks++; if (clear_busy_s !== 1'b0) $display("FAIL clear_done_busy got=%b want=0", clear_busy_s); else passes++;
      end
      cyc++;
    end
    fb_stall_s = 1'b0;
    checks++; if (done_cnt != 1) $display("FAIL clear_done_seen got=%0d want=1", done_cnt); else passes++;
    repeat (5) begin
      @(negedge clk);
      if (clear_done_s !== 1'b0 || fb_we_s !== 1'b0) extra++;
    end
    checks++; if (extra != 0) $display("FAIL clear_after_done got=%0d want=0", extra); else passes++;
    checks++; if (exp_q_s.size() != 0) $display("FAIL clear_pending got=%0d want=0", exp_q_s.size()); else passes++;
  endtask

  task automatic test_priority_and_reset();
    bit found = 1'b0;
    int bad = 0;
    @(posedge clk); #1;
    clear_req_s = 1'b1; clear_color_s = 24'h00FF00;
    pix_valid_s = 1'b1; pix_x_s = 10'd3; pix_y_s = 9'd0; pix_rgb_s = 24'h123456;
    for (int i = 0; i <= 10; i++) exp_q_s.push_back({19'(i), 24'h00FF00});
    @(negedge clk);
    checks++; if (pix_ready_s !== 1'b0) $display("FAIL prio_ready got=%b want=0", pix_ready_s); else passes++;
    @(posedge clk); #1;
    clear_req_s = 1'b0; pix_valid_s = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (fb_we_s === 1'b1 && fb_addr_s === 19'd10) found = 1'b1;
    end
    checks++; if (!found) $display("FAIL prio_reach_addr10 got=0 want=1"); else passes++;
    rst_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (fb_we_s !== 1'b0) $display("FAIL midclear_we got=%b want=0", fb_we_s); else passes++;
    @(posedge clk); #1;
    rst_s = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (clear_done_s !== 1'b0 || clear_busy_s !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL midclear_done_busy got=%0d want=0", bad); else passes++;
    checks++; if (exp_q_s.size() != 0) $display("FAIL midclear_pending got=%0d want=0", exp_q_s.size()); else passes++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0;
    clear_req = 1'b0; clear_color = '0; fb_stall = 1'b0;
    pix_valid_s = 1'b0; pix_x_s = '0; pix_y_s = '0; pix_rgb_s = '0;
    clear_req_s = 1'b0; clear_color_s = '0; fb_stall_s = 1'b0;
    test_reset();
    test_single_pixel();
    test_clip();
    test_back_to_back();
    test_clear(1'b0, 24'hFF0000);
    test_clear(1'b1, 24'hFF0000);
    test_priority_and_reset();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
